mc_bus_bridge: RTL and testbench
================================

MC_BUS_BRIDGE -- requirements
Module: mc_bus_bridge

Interface
REQ-001 Parameter MC_DATA_WIDTH, default 16, width of the external bus data and of the FIFO words.
REQ-002 Parameter MC_ADD_WIDTH, default 6, width of the external bus address.
REQ-003 clock  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 mc_ce  input  1  external chip enable, active-low, asynchronous to clock.
REQ-006 mc_we  input  1  external write strobe, active-low, asynchronous.
REQ-007 mc_oe  input  1  external read strobe, active-low, asynchronous.
REQ-008 mc_add  input  MC_ADD_WIDTH  external address, asynchronous.
REQ-009 mc_data_in  input  MC_DATA_WIDTH  data from the bus pad.
REQ-010 mc_data_out  output  MC_DATA_WIDTH  read data to the pad.
REQ-011 mc_data_oe  output  1  pad drive enable; high drives mc_data_out.
REQ-012 in_push, in_data[MC_DATA_WIDTH], in_is_cmd  outputs  one-cycle push of a word to the input FIFO; in_is_cmd=1 marks a command word.
REQ-013 in_full  input  1  input FIFO full.
REQ-014 out_data  input  MC_DATA_WIDTH  head word of the output FIFO (show-ahead).
REQ-015 out_empty  input  1  output FIFO empty.
REQ-016 out_pop  output  1  one-cycle pop of the output FIFO.

Function
REQ-017 mc_ce, mc_we, mc_oe SHALL each pass through a 2-flop synchronizer; mc_add and mc_data_in SHALL pass through 2 register stages aligned with the strobes.
REQ-018 A write event SHALL be a synchronized mc_we 0->1 transition while synchronized mc_ce=0 and synchronized mc_oe=1; a read event SHALL be a synchronized mc_oe 1->0 transition while mc_ce=0 and mc_we=1.
REQ-019 With mc_ce=1, or with mc_we and mc_oe both low, no event SHALL occur.
REQ-020 Write to 0x00: in_push=1 for one cycle, in_data=aligned data, in_is_cmd=0; write to 0x01: same with in_is_cmd=1.
REQ-021 in_push SHALL assert exactly 3 rising edges after the first edge that samples mc_we high (2 sync stages + 1 registered output).
REQ-022 Write to 0x00/0x01 with in_full=1 at event time: no push; sticky overflow flag SHALL set.
REQ-023 Write to 0x02 with data bit0=1 SHALL clear overflow and underflow; all other write addresses SHALL be ignored.
REQ-024 Read 0x00 with out_empty=0: out_pop=1 for one cycle and mc_data_out SHALL latch out_data in the same cycle; with out_empty=1: no pop, mc_data_out=0, sticky underflow SHALL set.
REQ-025 Read 0x02: mc_data_out = {zeros, underflow, overflow, in_full, out_empty} (bits 3..0), sampled at the read event.
REQ-026 Read of any other address: mc_data_out=0, no side effects.
REQ-027 mc_data_oe SHALL be high from the cycle after a read event until synchronized mc_oe returns high or synchronized mc_ce goes high; mc_data_out SHALL hold its value for the whole window.
REQ-028 Exactly one push or pop per strobe pulse regardless of pulse length; a pulse SHALL be low for at least 2 clock cycles to be guaranteed seen.
REQ-029 Simultaneous in_full change and write event: value of in_full in the event cycle decides.

Reset
REQ-030 During reset: in_push=0, in_is_cmd=0, in_data=0, out_pop=0, mc_data_out=0, mc_data_oe=0, overflow=underflow=0.
REQ-031 Strobe synchronizers SHALL reset to 1 (idle); an event SHALL only fire on a transition whose both levels were sampled after reset deasserts; a strobe already low at reset release counts once its low level is sampled.
REQ-032 Reset mid-read SHALL drop mc_data_oe the next edge and cancel any pending pop.

Verification
REQ-033 Write 0x01=0x0003 (we low 6 cycles) -> one in_push, in_data=0x0003, in_is_cmd=1, 3 edges after we rise.
REQ-034 Write 0x00=0x00FF then 0x00=0x0000 -> two pushes, in_is_cmd=0, data in order.
REQ-035 out_data=0xA5A5, out_empty=0, read 0x00 -> one out_pop, mc_data_out=0xA5A5, mc_data_oe high while oe low.
REQ-036 in_full=1, write 0x00=0x1234 -> no push; read 0x02 -> 0x0006 (overflow, in_full); write 0x02=0x0001, in_full=0, out_empty=1 -> read 0x02 returns 0x0001.
REQ-037 out_empty=1, read 0x00 -> no pop, data 0x0000, underflow bit set in 0x02.
REQ-038 mc_ce=1 during write/read, and we+oe both low -> no push, no pop, mc_data_oe=0; reset asserted during read window -> mc_data_oe=0 next edge.

Source files
------------

// File: rtl/mc_bus_bridge_if.sv
// mc_bus_bridge_if
// Groups the external asynchronous memory-style bus and the two FIFO-side
// handshakes of the bridge.
//   mc_ce/mc_we/mc_oe : active-low chip enable / write strobe / read strobe
//   mc_add, mc_data_in: external address and write data (asynchronous)
//   mc_data_out/_oe   : read data and pad drive enable
//   in_push/in_data/in_is_cmd, in_full : input FIFO write side
//   out_data/out_empty/out_pop         : output FIFO read side (show-ahead)
// Modports: slave = the bridge, master = whatever drives the bus and FIFOs.
interface mc_bus_bridge_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
);
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;
  logic                     in_push;
  logic [MC_DATA_WIDTH-1:0] in_data;
  logic                     in_is_cmd;
  logic                     in_full;
  logic [MC_DATA_WIDTH-1:0] out_data;
  logic                     out_empty;
  logic                     out_pop;

  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in, in_full, out_data, out_empty,
    output mc_data_out, mc_data_oe, in_push, in_data, in_is_cmd, out_pop
  );

  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_data_in, in_full, out_data, out_empty,
    input  mc_data_out, mc_data_oe, in_push, in_data, in_is_cmd, out_pop
  );
endinterface

// File: rtl/mc_bus_bridge.sv
// mc_bus_bridge
// Bridges an asynchronous active-low strobe bus onto a pair of FIFOs.
// Writes to 0x00/0x01 push data/command words, a write to 0x02 with bit0=1
// clears the sticky error flags. Reads of 0x00 pop the output FIFO, reads of
// 0x02 return {underflow, overflow, in_full, out_empty}.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mc_bus_bridge_if.slave (external bus + FIFO handshakes)
// Handshake semantics: in_push and out_pop are single-cycle strobes; the
// FIFO accepts/releases exactly one word in every cycle the strobe is high.
// The bridge never pushes while in_full is high and never pops while
// out_empty is high (it flags overflow/underflow instead).
module mc_bus_bridge #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
) (
  input logic            clock,
  input logic            reset,
  mc_bus_bridge_if.slave bus
);

  localparam logic [MC_ADD_WIDTH-1:0] ADDR_DATA = MC_ADD_WIDTH'(0);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CMD  = MC_ADD_WIDTH'(1);
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CTRL = MC_ADD_WIDTH'(2);

  // Two-flop synchronizers; they idle (reset) high so no edge is seen
  // until a real low level has been sampled after reset.
  logic [1:0]               ce_sync, we_sync, oe_sync;
  logic                     we_prev, oe_prev;
  logic [MC_ADD_WIDTH-1:0]  add_p1, add_p2;
  logic [MC_DATA_WIDTH-1:0] data_p1, data_p2;

  logic                     ce_s, we_s, oe_s;
  logic                     write_ev, read_ev;
  logic [MC_DATA_WIDTH-1:0] read_value;

  logic                     in_push_q, in_is_cmd_q, out_pop_q, data_oe_q;
  logic [MC_DATA_WIDTH-1:0] in_data_q, data_out_q;
  logic                     overflow, underflow;

  assign ce_s = ce_sync[1];
  assign we_s = we_sync[1];
  assign oe_s = oe_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      ce_sync <= 2'b11;
      we_sync <= 2'b11;
      oe_sync <= 2'b11;
      we_prev <= 1'b1;
      oe_prev <= 1'b1;
      add_p1  <= '0;
      add_p2  <= '0;
      data_p1 <= '0;
      data_p2 <= '0;
    end else begin
      ce_sync <= {ce_sync[0], bus.mc_ce};
      we_sync <= {we_sync[0], bus.mc_we};
      oe_sync <= {oe_sync[0], bus.mc_oe};
      we_prev <= we_s;
      oe_prev <= oe_s;
      add_p1  <= bus.mc_add;
      add_p2  <= add_p1;
      data_p1 <= bus.mc_data_in;
      data_p2 <= data_p1;
    end
  end

  // Edge detection on the synchronized strobes. Requiring the other strobe
  // high means overlapping we/oe low never produces an event.
  assign write_ev = we_s & ~we_prev & ~ce_s & oe_s;
  assign read_ev  = ~oe_s & oe_prev & ~ce_s & we_s;

  always_comb begin
    read_value = '0;
    if (add_p2 == ADDR_DATA) begin
      read_value = bus.out_empty ? '0 : bus.out_data;
    end else if (add_p2 == ADDR_CTRL) begin
      read_value = MC_DATA_WIDTH'({underflow, overflow, bus.in_full, bus.out_empty});
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_push_q   <= 1'b0;
      in_is_cmd_q <= 1'b0;
      in_data_q   <= '0;
      out_pop_q   <= 1'b0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      in_push_q <= 1'b0;
      out_pop_q <= 1'b0;

      if (write_ev) begin
        if (add_p2 == ADDR_DATA || add_p2 == ADDR_CMD) begin
          if (bus.in_full) begin
            overflow <= 1'b1;
          end else begin
            in_push_q   <= 1'b1;
            in_data_q   <= data_p2;
            in_is_cmd_q <= (add_p2 == ADDR_CMD);
          end
        end else if (add_p2 == ADDR_CTRL && data_p2[0]) begin
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
      end

      if (read_ev) begin
        data_out_q <= read_value;
        data_oe_q  <= 1'b1;
        if (add_p2 == ADDR_DATA) begin
          if (bus.out_empty) underflow <= 1'b1;
          else               out_pop_q <= 1'b1;
        end
      end else begin
        // Window closes once the read strobe or chip enable is released.
        data_oe_q <= data_oe_q & ~oe_s & ~ce_s;
      end
    end
  end

  assign bus.in_push     = in_push_q;
  assign bus.in_data     = in_data_q;
  assign bus.in_is_cmd   = in_is_cmd_q;
  assign bus.out_pop     = out_pop_q;
  assign bus.mc_data_out = data_out_q;
  assign bus.mc_data_oe  = data_oe_q;

endmodule

// File: tb/tb_mc_bus_bridge.sv
module tb_mc_bus_bridge;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int W  = DW + 1;  // {is_cmd, data}

  logic clock;
  logic reset;

  mc_bus_bridge_if #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW)) bus ();

  mc_bus_bridge #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int exp_pops = 0;
  int exp_pushes = 0;
  bit ovf_m = 1'b0;
  bit unf_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every push must match the next expected word; pops are counted.
  always @(negedge clock) begin
    if (bus.in_push === 1'b1) begin
      push_cnt++;
      if (exp_q.size() == 0) check_eq("spurious_push", 32'(bus.in_push), 32'd0);
      else check_eq("push_word", 32'({bus.in_is_cmd, bus.in_data}), 32'(exp_q.pop_front()));
    end
    if (bus.out_pop === 1'b1) pop_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int lowc, input bit ce_v);
    bit exp_push;
    @(negedge clock);
    bus.mc_add = a; bus.mc_data_in = d;
    bus.mc_ce = ce_v; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    repeat (2) @(negedge clock);
    bus.mc_we = 1'b0;
    repeat (lowc) @(negedge clock);
    // reference model: decided by in_full as driven during the strobe
    exp_push = 1'b0;
    if (!ce_v) begin
      if (a == 0 || a == 1) begin
        if (bus.in_full) ovf_m = 1'b1;
        else begin
          exp_push = 1'b1;
          exp_pushes++;
          exp_q.push_back({(a == 1), d});
        end
      end else if (a == 2 && d[0]) begin
        ovf_m = 1'b0;
        unf_m = 1'b0;
      end
    end
    bus.mc_we = 1'b1;
    repeat (2) @(posedge clock);
    #1 check_eq("push_early", 32'(bus.in_push), 32'd0);
    @(posedge clock);
    #1 check_eq("push_edge3", 32'(bus.in_push), 32'(exp_push));
    @(posedge clock);
    #1 check_eq("push_single", 32'(bus.in_push), 32'd0);
    @(negedge clock);
    bus.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input int lowc, input bit ce_v);
    logic [DW-1:0] exp_d;
    int exp_pop;
    int p0;
    @(negedge clock);
    bus.mc_add = a; bus.mc_ce = ce_v; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    repeat (2) @(negedge clock);
    exp_d = '0;
    exp_pop = 0;
    if (!ce_v) begin
      if (a == 0) begin
        if (bus.out_empty) unf_m = 1'b1;
        else begin
          exp_d = bus.out_data;
          exp_pop = 1;
        end
      end else if (a == 2) begin
        exp_d = DW'({unf_m, ovf_m, bus.in_full, bus.out_empty});
      end
    end
    exp_pops += exp_pop;
    p0 = pop_cnt;
    bus.mc_oe = 1'b0;
    for (int k = 1; k <= lowc; k++) begin
      @(posedge clock);
      #1;
      if (k >= 3) begin
        check_eq("data_oe_window", 32'(bus.mc_data_oe), 32'(!ce_v));
        if (!ce_v) check_eq("read_data", 32'(bus.mc_data_out), 32'(exp_d));
      end
    end
    @(negedge clock);
    bus.mc_oe = 1'b1;
    repeat (4) @(posedge clock);
    #1 check_eq("data_oe_release", 32'(bus.mc_data_oe), 32'd0);
    check_eq("pop_count", 32'(pop_cnt - p0), 32'(exp_pop));
    @(negedge clock);
    bus.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // we and oe both low together: neither edge may produce an event.
  task automatic both_low();
    int p0, q0;
    @(negedge clock);
    bus.mc_add = '0; bus.mc_data_in = 16'h0007; bus.out_empty = 1'b0;
    bus.mc_ce = 1'b0; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    repeat (2) @(negedge clock);
    p0 = pop_cnt; q0 = push_cnt;
    bus.mc_we = 1'b0; bus.mc_oe = 1'b0;
    repeat (4) @(posedge clock);
    #1 check_eq("both_low_oe", 32'(bus.mc_data_oe), 32'd0);
    @(negedge clock);
    bus.mc_we = 1'b1;
    repeat (4) @(posedge clock);
    #1 check_eq("both_low_we_rise_oe", 32'(bus.mc_data_oe), 32'd0);
    @(negedge clock);
    bus.mc_oe = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("both_low_pops", 32'(pop_cnt - p0), 32'd0);
    check_eq("both_low_pushes", 32'(push_cnt - q0), 32'd0);
    bus.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // Read of 0x00 interrupted by reset after rst_at edges of oe low.
  task automatic reset_mid_read(input int rst_at, input int exp_pop);
    int p0;
    @(negedge clock);
    bus.mc_add = '0; bus.out_empty = 1'b0; bus.out_data = 16'h5A5A;
    bus.mc_ce = 1'b0; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    repeat (2) @(negedge clock);
    p0 = pop_cnt;
    bus.mc_oe = 1'b0;
    repeat (rst_at) @(posedge clock);
    if (rst_at >= 3) begin
      #1 check_eq("rst_pre_oe", 32'(bus.mc_data_oe), 32'd1);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 check_eq("rst_drop_oe", 32'(bus.mc_data_oe), 32'd0);
    check_eq("rst_drop_pop", 32'(bus.out_pop), 32'd0);
    check_eq("rst_data_out", 32'(bus.mc_data_out), 32'd0);
    @(negedge clock);
    bus.mc_oe = 1'b1; bus.mc_ce = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ovf_m = 1'b0; unf_m = 1'b0;
    exp_pops += exp_pop;
    repeat (3) @(negedge clock);
    check_eq("rst_pop_count", 32'(pop_cnt - p0), 32'(exp_pop));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.mc_ce = 1'b1; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    bus.mc_add = '0; bus.mc_data_in = '0;
    bus.in_full = 1'b0; bus.out_data = '0; bus.out_empty = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_in_push", 32'(bus.in_push), 32'd0);
    check_eq("rst_in_is_cmd", 32'(bus.in_is_cmd), 32'd0);
    check_eq("rst_in_data", 32'(bus.in_data), 32'd0);
    check_eq("rst_out_pop", 32'(bus.out_pop), 32'd0);
    check_eq("rst_mc_data_out", 32'(bus.mc_data_out), 32'd0);
    check_eq("rst_mc_data_oe", 32'(bus.mc_data_oe), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // flags clear after reset, both FIFOs idle
    bus_read(6'h02, 4, 1'b0);

    // command and data writes
    bus_write(6'h01, 16'h0003, 6, 1'b0);
    bus_write(6'h00, 16'h00FF, 3, 1'b0);
    bus_write(6'h00, 16'h0000, 2, 1'b0);

    // pop from output FIFO
    bus.out_data = 16'hA5A5; bus.out_empty = 1'b0;
    bus_read(6'h00, 5, 1'b0);

    // overflow and its clear
    bus.in_full = 1'b1;
    bus_write(6'h00, 16'h1234, 4, 1'b0);
    bus_read(6'h02, 4, 1'b0);
    bus_write(6'h02, 16'h0001, 3, 1'b0);
    bus.in_full = 1'b0; bus.out_empty = 1'b1;
    bus_read(6'h02, 4, 1'b0);

    // underflow
    bus_read(6'h00, 4, 1'b0);
    bus_read(6'h02, 4, 1'b0);

    // ignored addresses and a clear with bit0=0
    bus_write(6'h02, 16'hFFFE, 3, 1'b0);
    bus_write(6'h05, 16'hBEEF, 3, 1'b0);
    bus_read(6'h3F, 4, 1'b0);
    bus_read(6'h02, 4, 1'b0);

    // chip enable high, overlapping strobes
    bus.out_empty = 1'b0; bus.out_data = 16'h0F0F;
    bus_write(6'h00, 16'h0055, 4, 1'b1);
    bus_read(6'h00, 4, 1'b1);
    both_low();

    // reset mid-read: before the pop and after the window opened
    reset_mid_read(2, 0);
    reset_mid_read(4, 1);
    bus_read(6'h02, 4, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      int r;
      r = $urandom_range(0, 4);
      if (r < 3) a = AW'(r);
      else if (r == 3) a = 6'h03;
      else a = AW'($urandom_range(4, 63));
      bus.in_full   = 1'($urandom_range(0, 1));
      bus.out_empty = 1'($urandom_range(0, 1));
      bus.out_data  = DW'($urandom);
      if ($urandom_range(0, 1) == 0)
        bus_write(a, DW'($urandom), $urandom_range(2, 6), ($urandom_range(0, 7) == 0));
      else
        bus_read(a, $urandom_range(3, 6), ($urandom_range(0, 7) == 0));
    end

    repeat (4) @(negedge clock);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check_eq("total_pushes", 32'(push_cnt), 32'(exp_pushes));
    check_eq("total_pops", 32'(pop_cnt), 32'(exp_pops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
